// File: rtl/pipe_stage_buf.sv
// FIFO-ordered inter-stage buffer for the req/ack pipeline, with flush for jump redirect.
// Optional stall/flush statistics counters are built when PIPE_BUF_STAT_EN is defined.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_up_req,
    output logic              o_up_ack,
    input  logic [DATA_W-1:0] i_up_data,
    output logic              o_dn_req,
    input  logic              i_dn_ack,
    output logic [DATA_W-1:0] o_dn_data,
    input  logic              i_flush,
    output logic              o_flush_ack,
    output logic [CNT_W-1:0]  o_count,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              flush_ack_q;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A full buffer never accepts, even when the head drains in the same cycle.
    assign o_up_ack    = (count_q != CNT_W'(DEPTH)) && !i_flush;
    assign o_dn_req    = (count_q != '0);
    assign o_dn_data   = mem_q[rd_ptr_q];
    assign o_count     = count_q;
    assign o_flush_ack = flush_ack_q;

    assign push = i_up_req && o_up_ack;
    assign pop  = o_dn_req && i_dn_ack && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flush_ack_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flush_ack_q <= i_flush;
        end
    end

    // Payloads survive a flush; only the valid state above is cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_up_data;
        end
    end

`ifdef PIPE_BUF_STAT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (i_up_req && !o_up_ack) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (i_flush)               flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 instance for handshake/flush/reset
// and a DEPTH=3 instance for wrapping streams.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DEPTH=2 instance
    logic        a_up_req = 0, a_up_ack, a_dn_req, a_dn_ack = 0, a_flush = 0, a_flush_ack;
    logic [63:0] a_up_data = '0, a_dn_data;
    logic [1:0]  a_count;
    logic [31:0] a_stall_cnt, a_flush_cnt;

    // DEPTH=3 instance
    logic        b_up_req = 0, b_up_ack, b_dn_req, b_dn_ack = 0, b_flush = 0, b_flush_ack;
    logic [63:0] b_up_data = '0, b_dn_data;
    logic [1:0]  b_count;
    logic [31:0] b_stall_cnt, b_flush_cnt;

`ifdef PIPE_BUF_STAT_EN
    localparam logic [31:0] EXP_STALL5 = 32'd5;
    localparam logic [31:0] EXP_STALL  = 32'd7;
    localparam logic [31:0] EXP_FLUSH  = 32'd3;
`else
    localparam logic [31:0] EXP_STALL5 = 32'd0;
    localparam logic [31:0] EXP_STALL  = 32'd0;
    localparam logic [31:0] EXP_FLUSH  = 32'd0;
`endif

    pipe_stage_buf #(.DATA_W(64), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst),
        .i_up_req(a_up_req), .o_up_ack(a_up_ack), .i_up_data(a_up_data),
        .o_dn_req(a_dn_req), .i_dn_ack(a_dn_ack), .o_dn_data(a_dn_data),
        .i_flush(a_flush), .o_flush_ack(a_flush_ack), .o_count(a_count),
        .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
    );

    pipe_stage_buf #(.DATA_W(64), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst),
        .i_up_req(b_up_req), .o_up_ack(b_up_ack), .i_up_data(b_up_data),
        .o_dn_req(b_dn_req), .i_dn_ack(b_dn_ack), .o_dn_data(b_dn_data),
        .i_flush(b_flush), .o_flush_ack(b_flush_ack), .o_count(b_count),
        .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_dn_req", a_dn_req, 0);
        chk("rst_count", a_count, 0);
        chk("rst_flush_ack", a_flush_ack, 0);
        chk("rst_dn_data", a_dn_data, 0);
        chk("rst_up_ack", a_up_ack, 1);
        chk("rst_stall", a_stall_cnt, 0);
        chk("rst_flushcnt", a_flush_cnt, 0);
        #10 rst = 1'b1;
        tick();

        // Fill DEPTH=2 with A, B; keep requesting C while full
        a_up_req = 1; a_up_data = 64'hA;
        tick();
        chk("t1_count1", a_count, 1);
        chk("t1_dn_req", a_dn_req, 1);
        chk("t1_head1", a_dn_data, 64'hA);
        a_up_data = 64'hB;
        tick();
        a_up_data = 64'hC;
        chk("t1_count2", a_count, 2);
        chk("t1_up_ack_full", a_up_ack, 0);
        chk("t1_head", a_dn_data, 64'hA);
        repeat (5) tick();
        chk("t1_hold_count", a_count, 2);
        chk("stat_stall5", a_stall_cnt, EXP_STALL5);

        // Full + pop: no pass-through
        a_dn_ack = 1;
        #1;
        chk("t2_up_ack", a_up_ack, 0);
        tick();
        chk("t2_count", a_count, 1);
        chk("t2_head", a_dn_data, 64'hB);
        a_dn_ack = 0; a_up_data = 64'hD;
        tick();
        chk("t2_refill", a_count, 2);

        // Flush with concurrent push and pop
        a_flush = 1; a_dn_ack = 1; a_up_data = 64'hE;
        #1;
        chk("t4_up_ack_flush", a_up_ack, 0);
        tick();
        a_flush = 0; a_dn_ack = 0; a_up_req = 0;
        chk("t4_count", a_count, 0);
        chk("t4_dn_req", a_dn_req, 0);
        chk("t4_flush_ack", a_flush_ack, 1);
        chk("t4_payload_kept", a_dn_data, 64'hD);
        tick();
        chk("t4_ack_pulse_end", a_flush_ack, 0);

        // Flush held two cycles -> two pulses
        a_flush = 1;
        tick();
        chk("t4_hold_ack1", a_flush_ack, 1);
        tick();
        a_flush = 0;
        chk("t4_hold_ack2", a_flush_ack, 1);
        chk("t4_hold_count", a_count, 0);
        tick();
        chk("t4_hold_ack_end", a_flush_ack, 0);
        chk("stat_stall", a_stall_cnt, EXP_STALL);
        chk("stat_flush", a_flush_cnt, EXP_FLUSH);

        // DEPTH=3 streaming 1..10 with downstream always ready
        b_dn_ack = 1; b_up_req = 1;
        for (int k = 1; k <= 10; k++) begin
            b_up_data = 64'(k);
            tick();
            chk($sformatf("t3_data%0d", k), b_dn_data, 64'(k));
            chk($sformatf("t3_count%0d", k), b_count, 1);
        end
        b_up_req = 0;
        tick();
        chk("t3_drain", b_dn_req, 0);
        b_dn_ack = 0; b_up_req = 1;
        for (int k = 0; k < 3; k++) begin
            b_up_data = 64'(8'h20 + k);
            tick();
        end
        b_up_req = 0;
        chk("t3_full_count", b_count, 3);
        chk("t3_full_ack", b_up_ack, 0);
        chk("t3_full_head", b_dn_data, 64'h20);

        // Async reset mid-stream with two entries held
        a_up_req = 1; a_up_data = 64'hF;
        tick();
        chk("t5_push_head", a_dn_data, 64'hF);
        a_up_data = 64'h10;
        tick();
        a_up_req = 0;
        chk("t5_pre_count", a_count, 2);
        #2 rst = 1'b0;
        #1;
        chk("t5_dn_req", a_dn_req, 0);
        chk("t5_count", a_count, 0);
        chk("t5_flush_ack", a_flush_ack, 0);
        chk("t5_dn_data", a_dn_data, 0);
        chk("t5_b_count", b_count, 0);
        chk("t5_stall", a_stall_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
